muldiv_seq: RTL

- Iterative multiply/divide sequencer for the EX stage of the 5-stage MIPS pipeline; sits beside the single-cycle ALU.
- Executes MULT, MULTU, DIV and DIVU over 32 add/sub-and-shift steps on one internal 33-bit adder, and owns the architectural HI/LO registers.
- Produces the stall request that freezes IF/ID/EX while an operation runs.
- Also services MTHI/MTLO writes.

---
 rtl/muldiv_pkg.sv | 34 +++
 rtl/muldiv_if.sv | 33 +++
 rtl/muldiv_addsub.sv | 24 ++
 rtl/muldiv_seq.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// muldiv_pkg : op encodings, FSM states and step count for muldiv_seq
// Rev 1.0
// ---------------------------------------------------------------------------
package muldiv_pkg;

  localparam int ITER = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    RUN  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_e;

  function automatic logic is_div(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// muldiv_if : request/result bundle between the EX stage and muldiv_seq
// Rev 1.0
// ---------------------------------------------------------------------------
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, flush, hi_we, lo_we, wdata,
    input  stall, busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, flush, hi_we, lo_we, wdata,
    output stall, busy, done, hi, lo
  );
endinterface
`default_nettype wire

// File: rtl/muldiv_addsub.sv
`default_nettype none
// ---------------------------------------------------------------------------
// muldiv_addsub : shared add/subtract with carry-out for multiply and divide
// Rev 1.0
// ---------------------------------------------------------------------------
module muldiv_addsub #(
  parameter int W = 33
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         sub,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] full;

  // Subtract as x + ~y + 1; carry-out set means no borrow (x >= y).
  assign full = {1'b0, x} + {1'b0, (sub ? ~y : y)} + {{W{1'b0}}, sub};
  assign sum  = full[W-1:0];
  assign cout = full[W];

endmodule
`default_nettype wire

// File: rtl/muldiv_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// muldiv_seq : iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO
// Rev 1.0
// ---------------------------------------------------------------------------
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = ITER
) (
  input  logic    clk,
  input  logic    reset,
  muldiv_if.slave bus
);

  localparam int            CW   = $clog2(ITER);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  state_e             state;
  state_e             state_nxt;
  logic [CW-1:0]      count;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [WIDTH-1:0]   opnd;
  logic               neg_q;
  logic               neg_r;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               done_q;
  logic               busy_q;

  logic               op_div;
  logic               op_signed;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic               div_zero;
  logic [WIDTH:0]     add_x;
  logic [WIDTH:0]     add_y;
  logic [WIDTH:0]     add_sum;
  logic               add_cout;
  logic [WIDTH:0]     mul_m;
  logic [WIDTH-1:0]   step_hi;
  logic [WIDTH-1:0]   step_lo;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign op_div    = is_div(op_q);
  assign op_signed = is_signed_op(op_q);
  assign a_neg     = op_signed & a_q[WIDTH-1];
  assign b_neg     = op_signed & b_q[WIDTH-1];
  assign a_abs     = a_neg ? -a_q : a_q;
  assign b_abs     = b_neg ? -b_q : b_q;
  assign div_zero  = op_div && (b_q == '0);

  // Divide shifts the next dividend bit into the partial remainder before the trial subtract.
  assign add_x = op_div ? {acc_hi, acc_lo[WIDTH-1]} : {1'b0, acc_hi};
  assign add_y = {1'b0, opnd};

  muldiv_addsub #(
    .W (WIDTH + 1)
  ) u_addsub (
    .x    (add_x),
    .y    (add_y),
    .sub  (op_div),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    mul_m = acc_lo[0] ? add_sum : {1'b0, acc_hi};
    if (op_div) begin
      step_hi = add_cout ? add_sum[WIDTH-1:0] : add_x[WIDTH-1:0];
      step_lo = {acc_lo[WIDTH-2:0], add_cout};
    end else begin
      step_hi = mul_m[WIDTH:1];
      step_lo = {mul_m[0], acc_lo[WIDTH-1:1]};
    end
  end

  assign prod     = {acc_hi, acc_lo};
  assign prod_fix = neg_q ? -prod : prod;
  assign quo_fix  = neg_q ? -acc_lo : acc_lo;
  assign rem_fix  = neg_r ? -acc_hi : acc_hi;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start && !bus.flush) state_nxt = PREP;
      PREP: begin
        if (bus.flush)    state_nxt = IDLE;
        else if (div_zero) state_nxt = DONE;
        else               state_nxt = RUN;
      end
      RUN: begin
        if (bus.flush)           state_nxt = IDLE;
        else if (count == LAST)  state_nxt = FIX;
      end
      FIX:     state_nxt = bus.flush ? IDLE : DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= '0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      done_q <= (state_nxt == DONE);
      busy_q <= (state_nxt inside {PREP, RUN, FIX});
      case (state)
        IDLE, DONE: begin
          count <= '0;
          if (state == IDLE && bus.start) begin
            op_q <= bus.op;
            a_q  <= bus.a;
            b_q  <= bus.b;
          end
          if (bus.hi_we) hi_q <= bus.wdata;
          if (bus.lo_we) lo_q <= bus.wdata;
        end
        PREP: begin
          count  <= '0;
          acc_hi <= '0;
          acc_lo <= a_abs;
          opnd   <= b_abs;
          neg_q  <= a_neg ^ b_neg;
          neg_r  <= a_neg;
          if (div_zero && !bus.flush) begin
            hi_q <= a_q;
            lo_q <= '1;
          end
        end
        RUN: begin
          count  <= bus.flush ? '0 : count + CW'(1);
          acc_hi <= step_hi;
          acc_lo <= step_lo;
        end
        FIX: begin
          count <= '0;
          if (!bus.flush) begin
            if (op_div) begin
              hi_q <= rem_fix;
              lo_q <= quo_fix;
            end else begin
              hi_q <= prod_fix[2*WIDTH-1:WIDTH];
              lo_q <= prod_fix[WIDTH-1:0];
            end
          end
        end
        default: count <= '0;
      endcase
    end
  end

  assign bus.stall = ((state == IDLE) && bus.start) || (state inside {PREP, RUN, FIX});
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;

endmodule
`default_nettype wire
